// File: rtl/uart_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_loader_pkg
// Shared definitions for the UART instruction-memory loader:
//   - loader_state_t : FSM states (COLLECT, COMMIT, DONE)
//   - DEF_TERM_WORD  : default end-of-program marker
//   - NUM_LANES      : bytes per instruction word
// No ports (package).
// -----------------------------------------------------------------------------
package uart_loader_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      COMMIT  = 2'd1,
      DONE    = 2'd2
   } loader_state_t;

   localparam logic [31:0] DEF_TERM_WORD = 32'hffff_ffff;
   localparam int unsigned NUM_LANES     = 4;

endpackage

// File: rtl/uart_imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// uart_imem_loader_byte_packer
// Packs received bytes little-endian into a 32-bit word. The first byte of a
// word lands in bits 7:0. The word is presented combinationally together with
// the byte that completes it, so the consumer can register it in the same
// edge that accepts the last byte.
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_valid      accept i_data into the current lane (already gated by caller)
//   i_data       received byte
//   i_clear      discard the partial word (break / timeout); wins over i_valid
//   o_word       {i_data, lanes 2..0}; meaningful when o_word_ready is high
//   o_word_ready this cycle's byte completes lane 3
//   o_partial    at least one lane holds a byte (LOADER_TIMEOUT_EN builds only)
// -----------------------------------------------------------------------------
module uart_imem_loader_byte_packer
   import uart_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic [7:0]  i_data,
   input  logic        i_clear,
   output logic [31:0] o_word,
   output logic        o_word_ready
`ifdef LOADER_TIMEOUT_EN
   ,
   output logic        o_partial
`endif
);

   localparam logic [1:0] LAST_LANE = 2'(NUM_LANES - 1);

   logic [1:0]  r_bc;
   logic [23:0] r_lanes;

   // Lane counter and shift-in of the first three bytes of a word
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bc    <= 2'd0;
         r_lanes <= 24'd0;
      end else if (i_clear) begin
         r_bc    <= 2'd0;
         r_lanes <= 24'd0;
      end else if (i_valid) begin
         // bc wraps 3 -> 0 on the completing byte
         r_bc <= r_bc + 2'd1;
         case (r_bc)
            2'd0:    r_lanes[7:0]   <= i_data;
            2'd1:    r_lanes[15:8]  <= i_data;
            2'd2:    r_lanes[23:16] <= i_data;
            default: r_lanes        <= 24'd0;
         endcase
      end
   end

   assign o_word       = {i_data, r_lanes};
   assign o_word_ready = i_valid & ~i_clear & (r_bc == LAST_LANE);

`ifdef LOADER_TIMEOUT_EN
   assign o_partial = (r_bc != 2'd0);
`endif

endmodule

// File: rtl/uart_imem_loader.sv
// -----------------------------------------------------------------------------
// uart_imem_loader
// Takes bytes from the UART receiver, packs them into 32-bit little-endian
// instruction words and writes them to sequential instruction-memory word
// addresses. The terminator word (TERM_WORD) is never written; it raises the
// sticky o_write_done. Filling the last address before the terminator raises
// o_load_overflow and o_write_done together.
//
// Optional feature (macro LOADER_TIMEOUT_EN): a partial word is discarded after
// TIMEOUT_CYCLES clocks without a new byte.
//
// Ports:
//   i_clk            system clock
//   i_rst            asynchronous active-high reset
//   i_uart_rx_valid  one-cycle strobe, i_uart_rx_data holds a new byte
//   i_uart_rx_data   received byte
//   i_uart_rx_break  BREAK detected; drops the partial word while collecting
//   o_imem_we        write strobe, one cycle per word
//   o_imem_addr      word address of the current write (held otherwise)
//   o_imem_wdata     word being written (held otherwise)
//   o_write_done     sticky, load finished
//   o_load_overflow  sticky, memory filled before the terminator
// -----------------------------------------------------------------------------
module uart_imem_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter logic [31:0] TERM_WORD = DEF_TERM_WORD
`ifdef LOADER_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_uart_rx_valid,
   input  logic [7:0]        i_uart_rx_data,
   input  logic              i_uart_rx_break,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_write_done,
   output logic              o_load_overflow
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   loader_state_t     r_state;
   logic [ADDR_W-1:0] r_addr;        // next address to write
   logic              r_imem_we;
   logic [ADDR_W-1:0] r_imem_addr;
   logic [31:0]       r_imem_wdata;
   logic              r_write_done;
   logic              r_load_overflow;

   logic              w_collect;
   logic              w_clear;
   logic              w_accept;
   logic              w_to_clr;
   logic [31:0]       w_word;
   logic              w_word_ready;

   assign w_collect = (r_state == COLLECT);

   // Break only resynchronises while collecting; in COMMIT the packer is
   // already empty and a coincident byte must still be taken as byte 0.
   assign w_clear  = (w_collect & i_uart_rx_break) | w_to_clr;
   assign w_accept = i_uart_rx_valid & (r_state != DONE) & ~w_clear;

`ifdef LOADER_TIMEOUT_EN
   localparam int unsigned     TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

   logic [TO_W-1:0] r_to_cnt;
   logic            w_partial;

   assign w_to_clr = w_collect & w_partial & (r_to_cnt == TO_MAX);

   // Inter-byte gap counter; saturates at TO_MAX until the next accepted byte
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_to_cnt <= '0;
      end else if (w_accept) begin
         r_to_cnt <= '0;
      end else if (w_collect && w_partial && (r_to_cnt != TO_MAX)) begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end
`else
   assign w_to_clr = 1'b0;
`endif

   uart_imem_loader_byte_packer u_packer (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_valid      (w_accept),
      .i_data       (i_uart_rx_data),
      .i_clear      (w_clear),
      .o_word       (w_word),
      .o_word_ready (w_word_ready)
`ifdef LOADER_TIMEOUT_EN
      ,
      .o_partial    (w_partial)
`endif
   );

   // Load FSM; outputs are registered on the edge that accepts the 4th byte so
   // the write strobe appears in the COMMIT cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state         <= COLLECT;
         r_addr          <= '0;
         r_imem_we       <= 1'b0;
         r_imem_addr     <= '0;
         r_imem_wdata    <= 32'd0;
         r_write_done    <= 1'b0;
         r_load_overflow <= 1'b0;
      end else begin
         case (r_state)
            COLLECT: begin
               if (w_word_ready) begin
                  r_state <= COMMIT;
                  if (w_word == TERM_WORD) begin
                     r_imem_we    <= 1'b0;
                     r_write_done <= 1'b1;
                  end else begin
                     r_imem_we    <= 1'b1;
                     r_imem_addr  <= r_addr;
                     r_imem_wdata <= w_word;
                     if (r_addr == ADDR_LAST) begin
                        r_load_overflow <= 1'b1;
                        r_write_done    <= 1'b1;
                     end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                     end
                  end
               end else begin
                  r_imem_we <= 1'b0;
               end
            end
            COMMIT: begin
               r_imem_we <= 1'b0;
               if (r_write_done) begin
                  r_state <= DONE;
               end else begin
                  r_state <= COLLECT;
               end
            end
            DONE: begin
               r_imem_we <= 1'b0;
            end
            default: begin
               r_imem_we <= 1'b0;
               r_state   <= DONE;
            end
         endcase
      end
   end

   assign o_imem_we       = r_imem_we;
   assign o_imem_addr     = r_imem_addr;
   assign o_imem_wdata    = r_imem_wdata;
   assign o_write_done    = r_write_done;
   assign o_load_overflow = r_load_overflow;

endmodule

// File: tb/tb_uart_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_imem_loader
// Drives two loaders (ADDR_W=8 and ADDR_W=2) with the same byte stream and
// compares every cycle against a byte-stream reference model.
// -----------------------------------------------------------------------------
module tb_uart_imem_loader;

   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [7:0]  data;
   logic        brk;

   logic        we_a, done_a, ovf_a;
   logic [7:0]  addr_a;
   logic [31:0] wd_a;
   logic        we_b, done_b, ovf_b;
   logic [1:0]  addr_b;
   logic [31:0] wd_b;

   int n_vec = 0;
   int n_err = 0;

   // reference model state, index 0: ADDR_W=8, index 1: ADDR_W=2
   int          depth [2] = '{256, 4};
   int          m_cnt [2];
   logic [31:0] m_part[2];
   int          m_addr[2];
   bit          m_done[2];
   bit          m_ovf [2];
   bit          m_comm[2];
   int          m_idle[2];
   bit          e_we  [2];
   int          e_addr[2];
   logic [31:0] e_wd  [2];

   always #5 clk = ~clk;

`ifdef LOADER_TIMEOUT_EN
   uart_imem_loader #(.ADDR_W(8), .TIMEOUT_CYCLES(TO)) dut_a (
`else
   uart_imem_loader #(.ADDR_W(8)) dut_a (
`endif
      .i_clk(clk), .i_rst(rst), .i_uart_rx_valid(valid), .i_uart_rx_data(data),
      .i_uart_rx_break(brk), .o_imem_we(we_a), .o_imem_addr(addr_a),
      .o_imem_wdata(wd_a), .o_write_done(done_a), .o_load_overflow(ovf_a));

`ifdef LOADER_TIMEOUT_EN
   uart_imem_loader #(.ADDR_W(2), .TIMEOUT_CYCLES(TO)) dut_b (
`else
   uart_imem_loader #(.ADDR_W(2)) dut_b (
`endif
      .i_clk(clk), .i_rst(rst), .i_uart_rx_valid(valid), .i_uart_rx_data(data),
      .i_uart_rx_break(brk), .o_imem_we(we_b), .o_imem_addr(addr_b),
      .o_imem_wdata(wd_b), .o_write_done(done_b), .o_load_overflow(ovf_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_part[k] = 32'd0; m_addr[k] = 0; m_done[k] = 1'b0;
         m_ovf[k] = 1'b0; m_comm[k] = 1'b0; m_idle[k] = 0;
         e_we[k] = 1'b0; e_addr[k] = 0; e_wd[k] = 32'd0;
      end
   endfunction

   // One clock of the byte-stream rules: a 4-byte group becomes a word,
   // terminator ends the load, last address ends it with overflow.
   function automatic void model_step(input bit v, input logic [7:0] d, input bit b);
      for (int k = 0; k < 2; k++) begin
         bit was_comm = m_comm[k];
         bit to_clr   = 1'b0;
         e_we[k]   = 1'b0;
         m_comm[k] = 1'b0;
         if (!m_done[k]) begin
`ifdef LOADER_TIMEOUT_EN
            to_clr = !was_comm && (m_cnt[k] > 0) && (m_idle[k] == TO);
`endif
            if ((b && !was_comm) || to_clr) begin
               m_cnt[k]  = 0;
               m_part[k] = 32'd0;
            end else if (v) begin
               m_part[k] = m_part[k] | (32'(d) << (8 * m_cnt[k]));
               m_cnt[k]++;
               m_idle[k] = 0;
               if (m_cnt[k] == 4) begin
                  m_comm[k] = 1'b1;
                  if (m_part[k] == 32'hffff_ffff) begin
                     m_done[k] = 1'b1;
                  end else begin
                     e_we[k]   = 1'b1;
                     e_addr[k] = m_addr[k];
                     e_wd[k]   = m_part[k];
                     if (m_addr[k] == depth[k] - 1) begin
                        m_ovf[k]  = 1'b1;
                        m_done[k] = 1'b1;
                     end else begin
                        m_addr[k]++;
                     end
                  end
                  m_cnt[k]  = 0;
                  m_part[k] = 32'd0;
               end
            end else if (m_cnt[k] > 0 && m_idle[k] < TO) begin
               m_idle[k]++;
            end
         end
      end
   endfunction

   task automatic check_outputs();
      chk("we_a",    32'(we_a),   32'(e_we[0]));
      chk("addr_a",  32'(addr_a), 32'(e_addr[0]));
      chk("wdata_a", wd_a,        e_wd[0]);
      chk("done_a",  32'(done_a), 32'(m_done[0]));
      chk("ovf_a",   32'(ovf_a),  32'(m_ovf[0]));
      chk("we_b",    32'(we_b),   32'(e_we[1]));
      chk("addr_b",  32'(addr_b), 32'(e_addr[1]));
      chk("wdata_b", wd_b,        e_wd[1]);
      chk("done_b",  32'(done_b), 32'(m_done[1]));
      chk("ovf_b",   32'(ovf_b),  32'(m_ovf[1]));
   endtask

   task automatic step(input bit v, input logic [7:0] d, input bit b);
      valid = v; data = d; brk = b;
      @(posedge clk); #1;
      valid = 1'b0; brk = 1'b0;
      model_step(v, d, b);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, w[8*i +: 8], 1'b0);
         if (i < 3) idle(gap);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_we",   32'({we_a, we_b}),     32'd0);
      chk("rst_addr", 32'({addr_a, addr_b}), 32'd0);
      chk("rst_wd",   wd_a | wd_b,           32'd0);
      chk("rst_flag", 32'({done_a, ovf_a, done_b, ovf_b}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [31:0] w;
      rst = 1'b1; valid = 1'b0; data = 8'h00; brk = 1'b0;
      model_reset();
      @(posedge clk); #1;
      do_reset();
      idle(2);

      // single word 13 01 01 ff
      send_word(32'hff01_0113, 0);
      chk("tA_we",   32'(we_a), 32'd1);
      chk("tA_wd",   wd_a,      32'hff01_0113);
      chk("tA_addr", 32'(addr_a), 32'd0);
      idle(2);

      // four words then terminator, then more traffic after done
      do_reset();
      send_word(32'h0000_0000, 1);
      send_word(32'h0000_0000, 0);
      send_word(32'hff01_0113, 2);
      send_word(32'h0081_2623, 0);
      send_word(32'hffff_ffff, 1);
      chk("tB_done", 32'(done_a), 32'd1);
      chk("tB_we",   32'(we_a),   32'd0);
      send_word(32'hffff_ffff, 0);
      for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0);
      chk("tB_addr_hold", 32'(addr_a), 32'd3);

      // break mid-word, then break coincident with a byte
      do_reset();
      step(1'b1, 8'h13, 1'b0);
      step(1'b1, 8'h01, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      send_word(32'h0081_2623, 0);
      chk("tC_wd", wd_a, 32'h0081_2623);
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b1);
      send_word(32'h7766_5544, 1);
      chk("tC_addr", 32'(addr_a), 32'd1);
      // break during COMMIT is ignored, the byte is byte 0
      step(1'b1, 8'haa, 1'b1);
      step(1'b1, 8'hbb, 1'b0);
      step(1'b1, 8'hcc, 1'b0);
      step(1'b1, 8'hdd, 1'b0);
      idle(1);

      // five ordinary words: dut_b overflows after the fourth
      do_reset();
      for (int i = 0; i < 5; i++) begin
         w = $urandom();
         if (w == 32'hffff_ffff) w = 32'h0;
         send_word(w, int'($urandom_range(0, 2)));
      end
      chk("tD_ovf_b", 32'({ovf_b, done_b}), 32'd3);
      chk("tD_ovf_a", 32'({ovf_a, done_a}), 32'd0);

      // reset after two bytes abandons the partial word
      do_reset();
      step(1'b1, 8'h55, 1'b0);
      step(1'b1, 8'h66, 1'b0);
      do_reset();
      send_word(32'h0040_0093, 0);
      chk("tE_wd", wd_a, 32'h0040_0093);

      // one byte, long gap, four bytes
      do_reset();
      step(1'b1, 8'h99, 1'b0);
      idle(150);
      send_word(32'h1234_5678, 0);
      idle(3);

      // random traffic with occasional breaks
      do_reset();
      for (int i = 0; i < 200; i++) begin
         int r;
         r = int'($urandom_range(0, 19));
         if (r == 0)      step(1'($urandom), 8'($urandom), 1'b1);
         else if (r < 14) step(1'b1, 8'($urandom), 1'b0);
         else             step(1'b0, 8'h00, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
